mips_multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control decoder. A Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback states, producing per-state datapath enables. Memory latency is a parameter, and each memory access is stretched over that many cycles. It sits between the instruction register and the shared-memory multi-cycle datapath.

---
 rtl/mips_multicycle_control.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute,
// memory and writeback, with memory accesses stretched over MEM_LAT cycles.
module mips_multicycle_control #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_in,
    input  logic [5:0] func_in,
    input  logic       zero_in,
    output logic       pcWrite_out,
    output logic       irWrite_out,
    output logic       iorD_out,
    output logic       memRead_out,
    output logic       memWrite_out,
    output logic       regWrite_out,
    output logic [1:0] regDst_out,
    output logic [1:0] memToReg_out,
    output logic       ALUSrcA_out,
    output logic [1:0] ALUSrcB_out,
    output logic       extCntrl_out,
    output logic [3:0] ALUCntrl_out,
    output logic [1:0] pcSrc_out,
    output logic       done_out,
    output logic       illegal_out
);

    localparam int CW = $clog2(16);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b1111;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_RWB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH,
        S_JUMP, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext;
        logic [3:0] alu;
        logic [1:0] pc_src;
        logic       done;
        logic       illegal;
        logic       branch;
        logic       bne;
    } ctl_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    op_q, op_d;
    logic [5:0]    func_q, func_d;
    ctl_t          ctl_q, ctl_d;
    logic          nop_now;

    function automatic state_t decode(input logic [5:0] op,
                                      input logic [5:0] fn);
        state_t s;
        s = S_HALT;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h2a: s = S_EXEC_R;
                6'h00:               s = S_FETCH;
                6'h08:               s = S_JUMP;
                default:             s = S_HALT;
            endcase
        end else begin
            case (op)
                6'h08, 6'h0a, 6'h0d, 6'h0f: s = S_EXEC_I;
                6'h23, 6'h2b:               s = S_MEM_ADDR;
                6'h04, 6'h05:               s = S_BRANCH;
                6'h02, 6'h03:               s = S_JUMP;
                default:                    s = S_HALT;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        func_d  = func_q;
        unique case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                if (cnt_q == LAST) begin
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                op_d    = op_in;
                func_d  = func_in;
                state_d = decode(op_in, func_in);
                cnt_d   = '0;
            end
            S_EXEC_R, S_EXEC_I: state_d = S_RWB;
            S_MEM_ADDR: begin
                state_d = (op_q == 6'h2b) ? S_MEM_WR : S_MEM_RD;
                cnt_d   = '0;
            end
            S_MEM_RD: begin
                if (cnt_q == LAST) begin
                    state_d = S_MEM_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEM_WR: begin
                if (cnt_q == LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RWB, S_MEM_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    // Outputs are computed for the state being entered and then registered.
    always_comb begin
        ctl_d = '0;
        unique case (state_d)
            S_FETCH: begin
                ctl_d.mem_read = 1'b1;
                if (cnt_d == LAST) begin
                    ctl_d.ir_write  = 1'b1;
                    ctl_d.pc_write  = 1'b1;
                    ctl_d.alu_src_b = 2'd1;
                    ctl_d.alu       = ALU_ADD;
                end
            end
            S_DECODE: begin
                ctl_d.alu_src_b = 2'd3;
                ctl_d.alu       = ALU_ADD;
                ctl_d.ext       = 1'b1;
            end
            S_EXEC_R: begin
                ctl_d.alu_src_a = 1'b1;
                case (func_d)
                    6'h22:   ctl_d.alu = ALU_SUB;
                    6'h2a:   ctl_d.alu = ALU_SLT;
                    default: ctl_d.alu = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 2'd2;
                ctl_d.ext       = (op_d != 6'h0d);
                case (op_d)
                    6'h0a:   ctl_d.alu = ALU_SLT;
                    6'h0d:   ctl_d.alu = ALU_OR;
                    6'h0f:   ctl_d.alu = ALU_LUI;
                    default: ctl_d.alu = ALU_ADD;
                endcase
            end
            S_RWB: begin
                ctl_d.reg_write = 1'b1;
                ctl_d.reg_dst   = (op_d == 6'h00) ? 2'd1 : 2'd0;
                ctl_d.done      = 1'b1;
            end
            S_MEM_ADDR: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 2'd2;
                ctl_d.ext       = 1'b1;
                ctl_d.alu       = ALU_ADD;
            end
            S_MEM_RD: begin
                ctl_d.ior_d    = 1'b1;
                ctl_d.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.mem_to_reg = 2'd1;
                ctl_d.done       = 1'b1;
            end
            S_MEM_WR: begin
                ctl_d.ior_d     = 1'b1;
                ctl_d.mem_write = 1'b1;
                ctl_d.done      = (cnt_d == LAST);
            end
            S_BRANCH: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu       = ALU_SUB;
                ctl_d.pc_src    = 2'd1;
                ctl_d.done      = 1'b1;
                ctl_d.branch    = 1'b1;
                ctl_d.bne       = (op_d == 6'h05);
            end
            S_JUMP: begin
                ctl_d.pc_write = 1'b1;
                ctl_d.done     = 1'b1;
                ctl_d.pc_src   = (op_d == 6'h00) ? 2'd3 : 2'd2;
                if (op_d == 6'h03) begin
                    ctl_d.reg_write  = 1'b1;
                    ctl_d.reg_dst    = 2'd2;
                    ctl_d.mem_to_reg = 2'd2;
                end
            end
            S_HALT:  ctl_d.illegal = 1'b1;
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            op_q    <= '0;
            func_q  <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            func_q  <= func_d;
            ctl_q   <= ctl_d;
        end
    end

    // A nop finishes in DECODE, before its opcode can be registered.
    assign nop_now = (state_q == S_DECODE) && (op_in == 6'h00) &&
                     (func_in == 6'h00);

    assign pcWrite_out  = ctl_q.pc_write |
                          (ctl_q.branch & (zero_in ^ ctl_q.bne));
    assign irWrite_out  = ctl_q.ir_write;
    assign iorD_out     = ctl_q.ior_d;
    assign memRead_out  = ctl_q.mem_read;
    assign memWrite_out = ctl_q.mem_write;
    assign regWrite_out = ctl_q.reg_write;
    assign regDst_out   = ctl_q.reg_dst;
    assign memToReg_out = ctl_q.mem_to_reg;
    assign ALUSrcA_out  = ctl_q.alu_src_a;
    assign ALUSrcB_out  = ctl_q.alu_src_b;
    assign extCntrl_out = ctl_q.ext;
    assign ALUCntrl_out = ctl_q.alu;
    assign pcSrc_out    = ctl_q.pc_src;
    assign done_out     = ctl_q.done | nop_now;
    assign illegal_out  = ctl_q.illegal;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Random instruction streams into four control FSMs with different
// memory latencies, checked every cycle against a per-instruction model.
module tb_mips_multicycle_control;

    localparam int NI = 4;
    localparam int LATS [NI] = '{1, 3, 4, 16};

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SLT = 4'b0111;
    localparam logic [3:0] ORR = 4'b0001;
    localparam logic [3:0] LUI = 4'b1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst;
    logic [NI-1:0] zi;
    logic [5:0]    opi [NI];
    logic [5:0]    fni [NI];
    logic [21:0]   obs [NI];

    for (genvar g = 0; g < NI; g++) begin : gi
        logic pcw, irw, iord, mrd, mwr, rw, asa, ext, dn, il;
        logic [1:0] rdst, m2r, asb, pcs;
        logic [3:0] aluc;
        mips_multicycle_control #(.MEM_LAT(LATS[g])) dut (
            .clk(clk), .reset(rst[g]),
            .op_in(opi[g]), .func_in(fni[g]), .zero_in(zi[g]),
            .pcWrite_out(pcw), .irWrite_out(irw), .iorD_out(iord),
            .memRead_out(mrd), .memWrite_out(mwr),
            .regWrite_out(rw), .regDst_out(rdst),
            .memToReg_out(m2r), .ALUSrcA_out(asa),
            .ALUSrcB_out(asb), .extCntrl_out(ext),
            .ALUCntrl_out(aluc), .pcSrc_out(pcs),
            .done_out(dn), .illegal_out(il)
        );
        assign obs[g] = {pcw, irw, iord, mrd, mwr, rw, rdst, m2r,
                         asa, asb, ext, aluc, pcs, dn, il};
    end

    int tests = 0;
    int fails = 0;

    // 0 R-alu, 1 nop, 2 jr, 3 imm, 4 lw, 5 sw, 6 branch, 7 j/jal, 8 illegal
    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h2a: return 0;
                6'h00:               return 1;
                6'h08:               return 2;
                default:             return 8;
            endcase
        end
        case (op)
            6'h08, 6'h0a, 6'h0d, 6'h0f: return 3;
            6'h23:                      return 4;
            6'h2b:                      return 5;
            6'h04, 6'h05:               return 6;
            6'h02, 6'h03:               return 7;
            default:                    return 8;
        endcase
    endfunction

    // Expected outputs on cycle k of an instruction (k=0 is first FETCH).
    function automatic logic [21:0] exp_at(input logic [5:0] op,
        input logic [5:0] fn, input int L, input int k, input logic z);
        logic pcw, irw, iord, mrd, mwr, rw, asa, ext, dn, il;
        logic [1:0] rdst, m2r, asb, pcs;
        logic [3:0] aluc;
        int c, j;
        {pcw, irw, iord, mrd, mwr, rw, asa, ext, dn, il} = '0;
        {rdst, m2r, asb, pcs} = '0;
        aluc = '0;
        c = cls(op, fn);
        j = k - L - 1;
        if (k < L) begin
            mrd = 1'b1;
            if (k == L - 1) begin
                irw = 1'b1; pcw = 1'b1; asb = 2'd1; aluc = ADD;
            end
        end else if (k == L) begin
            asb = 2'd3; aluc = ADD; ext = 1'b1; dn = (c == 1);
        end else begin
            case (c)
                0: if (j == 0) begin
                       asa = 1'b1;
                       aluc = (fn == 6'h20) ? ADD :
                              (fn == 6'h22) ? SUB : SLT;
                   end else begin
                       rw = 1'b1; rdst = 2'd1; dn = 1'b1;
                   end
                3: if (j == 0) begin
                       asa = 1'b1; asb = 2'd2; ext = (op != 6'h0d);
                       aluc = (op == 6'h08) ? ADD :
                              (op == 6'h0a) ? SLT :
                              (op == 6'h0d) ? ORR : LUI;
                   end else begin
                       rw = 1'b1; dn = 1'b1;
                   end
                4: if (j == 0) begin
                       asa = 1'b1; asb = 2'd2; ext = 1'b1; aluc = ADD;
                   end else if (j <= L) begin
                       iord = 1'b1; mrd = 1'b1;
                   end else begin
                       rw = 1'b1; m2r = 2'd1; dn = 1'b1;
                   end
                5: if (j == 0) begin
                       asa = 1'b1; asb = 2'd2; ext = 1'b1; aluc = ADD;
                   end else begin
                       iord = 1'b1; mwr = 1'b1; dn = (j == L);
                   end
                6: begin
                       asa = 1'b1; aluc = SUB; pcs = 2'd1; dn = 1'b1;
                       pcw = (op == 6'h04) ? z : ~z;
                   end
                2: begin pcw = 1'b1; dn = 1'b1; pcs = 2'd3; end
                7: begin
                       pcw = 1'b1; dn = 1'b1; pcs = 2'd2;
                       if (op == 6'h03) begin
                           rw = 1'b1; rdst = 2'd2; m2r = 2'd2;
                       end
                   end
                default: il = 1'b1;
            endcase
        end
        return {pcw, irw, iord, mrd, mwr, rw, rdst, m2r,
                asa, asb, ext, aluc, pcs, dn, il};
    endfunction

    function automatic int model_len(input logic [5:0] op,
                                     input logic [5:0] fn, input int L);
        logic [21:0] e;
        for (int k = 0; k < 200; k++) begin
            e = exp_at(op, fn, L, k, 1'b0);
            if (e[1]) return k + 1;
        end
        return -1;
    endfunction

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        int r;
        r = $urandom_range(0, 16);
        op = 6'h00;
        fn = 6'($urandom);
        case (r)
            0:  fn = 6'h20;
            1:  fn = 6'h22;
            2:  fn = 6'h2a;
            3:  fn = 6'h00;
            4:  fn = 6'h08;
            5:  op = 6'h08;
            6:  op = 6'h0a;
            7:  op = 6'h0d;
            8:  op = 6'h0f;
            9:  op = 6'h23;
            10: op = 6'h2b;
            11: op = 6'h04;
            12: op = 6'h05;
            13: op = 6'h02;
            14: op = 6'h03;
            15: op = ($urandom_range(0, 1) == 1) ? 6'h3f : 6'h01;
            default: fn = 6'h01;
        endcase
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [21:0] act,
                           input logic [21:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    int          k     [NI];
    bit          ini   [NI];
    int          hold  [NI];
    bit          mid   [NI];
    logic [5:0]  cop   [NI];
    logic [5:0]  cfn   [NI];
    logic [21:0] ex    [NI];

    initial begin
        logic [21:0] e;
        int L;
        rst = '1;
        zi  = '0;
        for (int i = 0; i < NI; i++) begin
            opi[i] = '0; fni[i] = '0;
            k[i] = 0; ini[i] = 1'b1; hold[i] = 2; mid[i] = 1'b0;
            cop[i] = '0; cfn[i] = '0;
        end

        chk_int("len_add_L1", model_len(6'h00, 6'h20, 1), 4);
        chk_int("len_lw_L3", model_len(6'h23, 6'h11, 3), 9);
        chk_int("len_sw_L4", model_len(6'h2b, 6'h00, 4), 10);
        chk_int("len_nop_L1", model_len(6'h00, 6'h00, 1), 2);
        chk_int("len_beq_L16", model_len(6'h04, 6'h00, 16), 18);
        chk_int("len_jal_L1", model_len(6'h03, 6'h00, 1), 3);
        e = exp_at(6'h0d, 6'h00, 1, 2, 1'b0);
        chk_int("ori_alu", int'(e[7:4]), 1);
        chk_int("ori_ext", int'(e[8]), 0);
        e = exp_at(6'h0a, 6'h00, 1, 2, 1'b0);
        chk_int("slti_alu", int'(e[7:4]), 7);
        chk_int("slti_ext", int'(e[8]), 1);
        chk_vec("jal_vec", exp_at(6'h03, 6'h00, 1, 2, 1'b0),
                22'b100001_10_10_0_00_0_0000_10_1_0);
        e = exp_at(6'h04, 6'h00, 1, 2, 1'b1);
        chk_int("beq_z1_pcw", int'(e[21]), 1);
        chk_int("beq_pcsrc", int'(e[3:2]), 1);
        e = exp_at(6'h05, 6'h00, 1, 2, 1'b1);
        chk_int("bne_z1_pcw", int'(e[21]), 0);

        repeat (6000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                L = LATS[i];
                if (hold[i] > 0) begin
                    rst[i] = 1'b1;
                    hold[i]--;
                end else if (!ini[i] && cls(cop[i], cfn[i]) == 8 &&
                             k[i] > L + 20) begin
                    rst[i] = 1'b1;
                    hold[i] = 1;
                end else if (i == 2 && !ini[i] && !mid[i] &&
                             cls(cop[i], cfn[i]) == 4 && k[i] == L + 3) begin
                    rst[i] = 1'b1;
                    hold[i] = 1;
                    mid[i] = 1'b1;
                end else begin
                    rst[i] = ($urandom_range(0, 599) == 0);
                end
                if (rst[i]) ini[i] = 1'b1;
                if (!ini[i] && k[i] == L) begin
                    opi[i] = cop[i];
                    fni[i] = cfn[i];
                end else begin
                    opi[i] = 6'($urandom);
                    fni[i] = 6'($urandom);
                end
                zi[i] = 1'($urandom);
                ex[i] = ini[i] ? 22'd0 :
                        exp_at(cop[i], cfn[i], L, k[i], zi[i]);
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                chk_vec($sformatf("inst%0d L=%0d op=%h fn=%h k=%0d rst=%0d",
                        i, LATS[i], cop[i], cfn[i], k[i], rst[i]),
                        obs[i], ex[i]);
                if (rst[i]) begin
                    ini[i] = 1'b1;
                end else if (ini[i]) begin
                    ini[i] = 1'b0;
                    k[i] = 0;
                    pick(cop[i], cfn[i]);
                end else if (ex[i][1]) begin
                    k[i] = 0;
                    pick(cop[i], cfn[i]);
                end else begin
                    k[i]++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
